// File: rtl/cpu_pkg.sv
// Shared CPU core types: register address, data word and register count.
package cpu_pkg;

    localparam int CPU_ADDR_WIDTH = 5;
    localparam int CPU_DATA_WIDTH = 32;
    localparam int NUM_REGS       = 2 ** CPU_ADDR_WIDTH;

    typedef logic [CPU_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [CPU_DATA_WIDTH-1:0] xlen_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for in-flight long-latency results, with three
// combinational hazard lookups and a sticky error for clears of idle registers.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    output logic                  busy_rs1,
    output logic                  busy_rs2,
    output logic                  busy_rd,
    output logic                  sb_err
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [NREGS-1:0] busy;

    // NOTE: the busy array is plain flops, so it must be reset explicitly; a
    // stale bit after reset would stall decode forever.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= '0;
            sb_err <= 1'b0;
        end else begin
            if (clr_en && clr_addr != '0) begin
                busy[clr_addr] <= 1'b0;
                if (!busy[clr_addr])
                    sb_err <= 1'b1;
            end
            // NOTE: the later non-blocking assignment wins, so set beats clear.
            if (set_en && set_addr != '0)
                busy[set_addr] <= 1'b1;
        end
    end

    // busy[0] is never written, so x0 lookups read zero.
    assign busy_rs1 = busy[rs1];
    assign busy_rs2 = busy[rs2];
    assign busy_rd  = busy[rd];

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port between pipeline writeback
// and a long-latency unit, and raises the decode stall for LU hazards.
module regfile_wb_scheduler
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH      = CPU_DATA_WIDTH,
    parameter int ADDR_WIDTH      = CPU_ADDR_WIDTH,
    parameter int STARVE_LIMIT    = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [ADDR_WIDTH-1:0] id_rs1,
    input  logic [ADDR_WIDTH-1:0] id_rs2,
    input  logic [ADDR_WIDTH-1:0] id_rd,
    input  logic                  id_rd_we,
    input  logic                  id_long,
    output logic                  id_stall,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_waddr,
    input  logic [DATA_WIDTH-1:0] wb_wdata,
    input  logic                  lu_valid,
    input  logic [ADDR_WIDTH-1:0] lu_waddr,
    input  logic [DATA_WIDTH-1:0] lu_wdata,
    output logic                  lu_ready,
    output logic                  reg_wr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  sb_err
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;

    logic [OW-1:0] outstanding;
    logic [SW-1:0] starve_cnt;
    logic          starve_stall;
    logic          hz_rs1, hz_rs2, busy_rd;
    logic          full_long, lu_commit, lu_blocked, long_issue;

    // NOTE: every output gets a default first so this block cannot infer latches.
    always_comb begin
        reg_wr   = 1'b0;
        lu_ready = 1'b0;
        waddr    = '0;
        wdata    = '0;
        if (!rst) begin
            if (wb_valid) begin
                reg_wr = (wb_waddr != '0);
                waddr  = wb_waddr;
                wdata  = wb_wdata;
            end else if (lu_valid) begin
                lu_ready = 1'b1;
                reg_wr   = (lu_waddr != '0);
                waddr    = lu_waddr;
                wdata    = lu_wdata;
            end
        end
    end

    assign lu_commit  = lu_valid & lu_ready;
    assign lu_blocked = lu_valid & ~lu_ready;
    assign full_long  = id_long & (outstanding == OW'(MAX_OUTSTANDING));
    assign id_stall   = rst | (id_valid & (hz_rs1 | hz_rs2 | (id_rd_we & busy_rd)
                                           | full_long | starve_stall));
    assign long_issue = id_valid & ~id_stall & id_long;

    reg_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (long_issue & id_rd_we),
        .set_addr (id_rd),
        .clr_en   (lu_commit),
        .clr_addr (lu_waddr),
        .rs1      (id_rs1),
        .rs2      (id_rs2),
        .rd       (id_rd),
        .busy_rs1 (hz_rs1),
        .busy_rs2 (hz_rs2),
        .busy_rd  (busy_rd),
        .sb_err   (sb_err)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else if (long_issue && !lu_commit && outstanding != OW'(MAX_OUTSTANDING)) begin
            outstanding <= outstanding + 1'b1;
        end else if (!long_issue && lu_commit && outstanding != '0) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    // A blocked LU eventually freezes issue so the pipeline drains and WB idles.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt   <= '0;
            starve_stall <= 1'b0;
        end else begin
            if (lu_blocked) begin
                if (starve_cnt == SW'(STARVE_LIMIT - 1))
                    starve_stall <= 1'b1;
                else
                    starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
            if (lu_commit)
                starve_stall <= 1'b0;
        end
    end

endmodule
